dmem_port_arbiter: RTL and testbench

- Shares the single-port word-addressed Data memory between two requesters.
- Requester 0 is the CPU load/store stage. Requester 1 is the loader/debug DMA that preloads arrays and dumps results.
- Round-robin arbitration, optional bus lock for multi-word bursts, and a bounded-hold anti-starvation counter.
- Sits between the requesters and the memory's r_addr/w_addr/w_en/din/dout pins. The memory has a combinational read and writes on posedge when w_en is high.

---
 rtl/dmem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the CPU load/store stage (port 0)
// and the loader/debug DMA (port 1): round-robin, bus lock, bounded hold.
module dmem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [1:0]    owner,
  output logic [AW-1:0] mem_r_addr,
  output logic [AW-1:0] mem_w_addr,
  output logic          mem_w_en,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state_r, state_s;
  logic          last_r, last_s;   // index of the port that won most recently
  logic [HW-1:0] hold_r, hold_s;
  logic          gnt0_s, gnt1_s;
  logic [AW-1:0] addr_s;
  logic          rvalid0_r, rvalid1_r;
  logic [DW-1:0] rdata0_r, rdata1_r;

  // Arbitration, lock ownership and anti-starvation next-state logic
  always_comb begin
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    state_s = state_r;
    last_s  = last_r;
    hold_s  = hold_r;
    case (state_r)
      IDLE: begin
        hold_s = '0;
        if (req0 && req1) begin
          if (last_r) gnt0_s = 1'b1;
          else        gnt1_s = 1'b1;
        end else if (req0) begin
          gnt0_s = 1'b1;
        end else if (req1) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b0;
        end
        if (gnt0_s) begin
          last_s  = 1'b0;
          state_s = lock0 ? OWN0 : IDLE;
        end else if (gnt1_s) begin
          last_s  = 1'b1;
          state_s = lock1 ? OWN1 : IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      OWN0: begin
        gnt0_s = req0;
        // Waiting port has been held off long enough: break the lock
        if (req1 && HOLD_EN && (hold_r == HOLD_LAST)) begin
          state_s = IDLE;
          last_s  = 1'b0;
          hold_s  = '0;
        end else if (!req0 || !lock0) begin
          state_s = IDLE;
          hold_s  = '0;
        end else if (req1) begin
          hold_s = hold_r + HW'(1);
        end else begin
          hold_s = hold_r;
        end
      end
      OWN1: begin
        gnt1_s = req1;
        if (req0 && HOLD_EN && (hold_r == HOLD_LAST)) begin
          state_s = IDLE;
          last_s  = 1'b1;
          hold_s  = '0;
        end else if (!req1 || !lock1) begin
          state_s = IDLE;
          hold_s  = '0;
        end else if (req0) begin
          hold_s = hold_r + HW'(1);
        end else begin
          hold_s = hold_r;
        end
      end
      default: begin
        state_s = IDLE;
        hold_s  = '0;
      end
    endcase
  end

  // Route the granted port onto the memory pins
  always_comb begin
    addr_s   = '0;
    mem_din  = '0;
    mem_w_en = 1'b0;
    if (gnt0_s) begin
      addr_s   = addr0;
      mem_din  = wdata0;
      mem_w_en = we0;
    end else if (gnt1_s) begin
      addr_s   = addr1;
      mem_din  = wdata1;
      mem_w_en = we1;
    end else begin
      mem_w_en = 1'b0;
    end
  end

  // Arbiter state, round-robin pointer and hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      hold_r  <= '0;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      hold_r  <= hold_s;
    end
  end

  // One-cycle read return; rdata holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
    end else begin
      rvalid0_r <= gnt0_s & ~we0;
      rvalid1_r <= gnt1_s & ~we1;
      if (gnt0_s && !we0) rdata0_r <= mem_dout;
      if (gnt1_s && !we1) rdata1_r <= mem_dout;
    end
  end

  assign gnt0       = gnt0_s;
  assign gnt1       = gnt1_s;
  assign rvalid0    = rvalid0_r;
  assign rvalid1    = rvalid1_r;
  assign rdata0     = rdata0_r;
  assign rdata1     = rdata1_r;
  assign mem_r_addr = addr_s;
  assign mem_w_addr = addr_s;
  assign owner      = (state_r == OWN0) ? 2'b01 :
                      (state_r == OWN1) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: inline grant/owner checks plus a
// scoreboard of expected read returns consumed by a monitor process.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  owner;
  logic [31:0] mem_r_addr, mem_w_addr, mem_din, mem_dout;
  logic        mem_w_en;

  logic [31:0] mem [0:15];
  logic [32:0] sb [$];   // {port, data}
  int          total  = 0;
  int          passed = 0;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .owner(owner),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr),
    .mem_w_en(mem_w_en), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, posedge write
  assign mem_dout = mem[mem_r_addr[3:0]];
  always @(posedge clk) if (mem_w_en) mem[mem_w_addr[3:0]] <= mem_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic pop_cmp(input int p, input logic [31:0] d);
    logic [32:0] e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL unexpected_rvalid: port %0d returned %0h, required no rvalid", p, d);
    end else begin
      e = sb.pop_front();
      chk("rvalid_port", 32'(p), 32'(e[32]));
      chk("rdata", d, e[31:0]);
    end
  endtask

  // Monitor: every rvalid pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid0) pop_cmp(0, rdata0);
      if (rvalid1) pop_cmp(1, rdata1);
    end
  end

  task automatic p0(input logic r, input logic l, input logic w, input logic [31:0] a, input logic [31:0] d);
    req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d;
  endtask
  task automatic p1(input logic r, input logic l, input logic w, input logic [31:0] a, input logic [31:0] d);
    req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic gnts(input string nm, input logic g0, input logic g1);
    #2;
    chk({nm, "_gnt0"}, 32'(gnt0), 32'(g0));
    chk({nm, "_gnt1"}, 32'(gnt1), 32'(g1));
  endtask
  task automatic push(input logic p, input logic [31:0] d);
    sb.push_back({p, d});
  endtask

  initial begin
    rst = 1'b1;
    p0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    p1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(); tick(); #2;
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);

    // Preload addr 0/1 with 20/40 via port 0
    tick(); rst = 1'b0; p0(1'b1, 1'b0, 1'b1, 32'd0, 32'd20);
    gnts("pre0", 1'b1, 1'b0);
    chk("pre0_wen", 32'(mem_w_en), 32'd1);
    tick(); p0(1'b1, 1'b0, 1'b1, 32'd1, 32'd40);
    gnts("pre1", 1'b1, 1'b0);

    // Reset in the cycle after a locked read
    tick(); p0(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    gnts("t1_read", 1'b1, 1'b0);
    tick(); rst = 1'b1; p0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2;
    chk("t1_rvalid0", 32'(rvalid0), 32'd0);
    chk("t1_owner", 32'(owner), 32'd0);
    chk("t1_rdata0", rdata0, 32'd0);

    // Continuous reads from both ports alternate, port 0 wins first tie
    tick(); rst = 1'b0;
    p0(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    p1(1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    push(1'b0, 32'd20); gnts("t3_c0", 1'b1, 1'b0);
    tick(); push(1'b1, 32'd40); gnts("t3_c1", 1'b0, 1'b1);
    tick(); push(1'b0, 32'd20); gnts("t3_c2", 1'b1, 1'b0);
    tick(); push(1'b1, 32'd40); gnts("t3_c3", 1'b0, 1'b1);

    // Write then read-back of the same address
    tick(); p1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0); p0(1'b1, 1'b0, 1'b1, 32'd3, 32'd55);
    gnts("t2_wr", 1'b1, 1'b0);
    chk("t2_wen", 32'(mem_w_en), 32'd1);
    chk("t2_waddr", mem_w_addr, 32'd3);
    chk("t2_din", mem_din, 32'd55);
    tick(); p0(1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
    push(1'b0, 32'd55); gnts("t2_rd", 1'b1, 1'b0);
    chk("t2_rd_wen", 32'(mem_w_en), 32'd0);
    tick(); p0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(); #2;
    chk("t2_hold_rvalid0", 32'(rvalid0), 32'd0);
    chk("t2_hold_rdata0", rdata0, 32'd55);

    // Port 1 locked burst of four writes to 8..11
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      p1(1'b1, (i != 3), 1'b1, 32'(8 + i), 32'(100 + i));
      gnts("t4_burst", 1'b0, 1'b1);
      chk("t4_wen", 32'(mem_w_en), 32'd1);
      chk("t4_owner", 32'(owner), (i == 0) ? 32'd0 : 32'd2);
    end
    tick(); p1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0); #2;
    chk("t4_owner_idle", 32'(owner), 32'd0);

    // Port 1 holds lock forever; port 0 must win on its 9th waiting cycle
    tick(); p1(1'b1, 1'b1, 1'b1, 32'd12, 32'd7);
    gnts("t5_lock", 1'b0, 1'b1);
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n == 1) p0(1'b1, 1'b0, 1'b0, 32'd9, 32'd0);
      if (n == 9) push(1'b0, 32'd101);
      gnts("t5_hold", (n == 9), (n != 9));
      chk("t5_owner", 32'(owner), (n == 9) ? 32'd0 : 32'd2);
    end
    tick(); p0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    gnts("t5_after", 1'b0, 1'b1);
    tick(); p1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Simultaneous port 0 read / port 1 write with last winner = port 0
    tick(); p0(1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    push(1'b0, 32'd40); gnts("t6_setup", 1'b1, 1'b0);
    tick(); p0(1'b1, 1'b0, 1'b0, 32'd5, 32'd0); p1(1'b1, 1'b0, 1'b1, 32'd5, 32'd77);
    gnts("t6_wr", 1'b0, 1'b1);
    chk("t6_wen", 32'(mem_w_en), 32'd1);
    chk("t6_waddr", mem_w_addr, 32'd5);
    tick(); p1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    push(1'b0, 32'd77); gnts("t6_rd", 1'b1, 1'b0);
    tick(); p0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    tick(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
